// File: rtl/display_scanout.sv
// Raster scan-out: programmable sync/DE timing, FIFO-fed 1/2/4/8 bpp unpacking with
// optional horizontal replication, 256x24 palette lookup; video outputs lag counters by one cycle.
module display_scanout #(
  parameter int          H_RES    = 1024,
  parameter int          V_RES    = 768,
  parameter int          H_FP     = 48,
  parameter int          H_SYNC   = 104,
  parameter int          H_BP     = 152,
  parameter int          V_FP     = 3,
  parameter int          V_SYNC   = 4,
  parameter int          V_BP     = 23,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int          H_SCALE  = 1,
  parameter logic [23:0] UF_COLOR = 24'h000000
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        pixel_empty_n,
  input  logic [31:0] pixel_word,
  output logic        pixel_deq,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_data,
  input  logic        underflow_clr,
  output logic        underflow,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);

  localparam logic signed [15:0] H_STA  = 16'(H_STA_I);
  localparam logic signed [15:0] HS_STA = 16'(H_STA_I + H_FP);
  localparam logic signed [15:0] HS_END = 16'(H_STA_I + H_FP + H_SYNC);
  localparam logic signed [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic signed [15:0] V_STA  = 16'(V_STA_I);
  localparam logic signed [15:0] VS_STA = 16'(V_STA_I + V_FP);
  localparam logic signed [15:0] VS_END = 16'(V_STA_I + V_FP + V_SYNC);
  localparam logic signed [15:0] V_LAST = 16'(V_RES - 1);

  localparam int         SCALE_SH   = (H_SCALE == 4) ? 2 : (H_SCALE == 2) ? 1 : 0;
  localparam logic [1:0] SCALE_MASK = 2'(H_SCALE - 1);

  logic signed [15:0] posx_q, posx_d;
  logic signed [15:0] posy_q, posy_d;
  logic [1:0]         mode_r_q, mode_r_d;
  logic [31:0]        word_q, word_d;
  logic               grp_uf_q, grp_uf_d;
  logic               underflow_q, underflow_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic               frame_start_q, frame_start_d;
  logic               uf_pix_q, uf_pix_d;

  logic [23:0]        pal_mem [256];
  logic [23:0]        pal_rd_q;

  logic               at_origin;
  logic               active;
  logic               fetch;
  logic [4:0]         slot_mask;
  logic [4:0]         slot;
  logic [4:0]         shamt;
  logic [7:0]         idx_mask;
  logic [31:0]        cur_word;
  logic [7:0]         pix_idx;

  always_comb begin
    at_origin = (posx_q == H_STA) && (posy_q == V_STA);
    active    = !posx_q[15] && !posy_q[15];

    slot_mask = 5'd3;
    idx_mask  = 8'hFF;
    case (mode_r_q)
      2'd0: begin slot_mask = 5'd31; idx_mask = 8'h01; end
      2'd1: begin slot_mask = 5'd15; idx_mask = 8'h03; end
      2'd2: begin slot_mask = 5'd7;  idx_mask = 8'h0F; end
      default: begin slot_mask = 5'd3; idx_mask = 8'hFF; end
    endcase

    // slot is only meaningful inside the active region, where posx is non-negative
    slot  = 5'($unsigned(posx_q) >> SCALE_SH) & slot_mask;
    fetch = active && (slot == 5'd0) && ((posx_q[1:0] & SCALE_MASK) == 2'd0);

    pixel_deq = fetch && pixel_empty_n;
    cur_word  = fetch ? pixel_word : word_q;
    shamt     = slot << mode_r_q;
    pix_idx   = 8'(cur_word >> shamt) & idx_mask;

    word_d   = pixel_deq ? pixel_word : word_q;
    grp_uf_d = fetch ? !pixel_empty_n : grp_uf_q;
    uf_pix_d = grp_uf_d;

    // a set in the same cycle as a clear must leave the flag raised
    if (fetch && !pixel_empty_n) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end

    mode_r_d = at_origin ? mode : mode_r_q;

    if (posx_q == H_LAST) begin
      posx_d = H_STA;
      posy_d = (posy_q == V_LAST) ? V_STA : posy_q + 16'sd1;
    end else begin
      posx_d = posx_q + 16'sd1;
      posy_d = posy_q;
    end

    hs_d          = ((posx_q > HS_STA) && (posx_q <= HS_END)) ? H_POL : ~H_POL;
    vs_d          = ((posy_q > VS_STA) && (posy_q <= VS_END)) ? V_POL : ~V_POL;
    de_d          = active;
    frame_start_d = at_origin;
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      posx_q        <= H_STA;
      posy_q        <= V_STA;
      mode_r_q      <= 2'd3;
      word_q        <= '0;
      grp_uf_q      <= 1'b0;
      underflow_q   <= 1'b0;
      hs_q          <= ~H_POL;
      vs_q          <= ~V_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      uf_pix_q      <= 1'b0;
    end else begin
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      mode_r_q      <= mode_r_d;
      word_q        <= word_d;
      grp_uf_q      <= grp_uf_d;
      underflow_q   <= underflow_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      uf_pix_q      <= uf_pix_d;
    end
  end

  // Palette RAM: read-before-write, no reset so it maps onto block RAM
  always_ff @(posedge pix_clk) begin
    if (pal_we) begin
      pal_mem[pal_addr] <= pal_data;
    end
    pal_rd_q <= pal_mem[pix_idx];
  end

  assign {red, green, blue} = !de_q ? 24'h000000 : (uf_pix_q ? UF_COLOR : pal_rd_q);
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: doc/display_scanout.md
# display_scanout

Parametrised raster scan-out engine for the kinnow display path. It generates programmable sync/DE timing and dequeues 32-bit framebuffer words from the pixel FIFO. It unpacks 1/2/4/8 bpp indexed pixels, selected at run time, with optional horizontal pixel replication, and maps them through a CPU-writable 256×24-bit palette. It also flags FIFO underflow and drives RGB888 to the video encoder.

## Interface
- H_RES, 1024: active pixels per line
- V_RES, 768: active lines per frame
- H_FP / H_SYNC / H_BP, 48 / 104 / 152: horizontal porch and sync widths (cycles)
- V_FP / V_SYNC / V_BP, 3 / 4 / 23: vertical porch and sync widths (lines)
- H_POL / V_POL, 0 / 0: sync polarity, 1 = active-high
- H_SCALE, 1: horizontal replication factor; legal values are 1, 2 and 4
- UF_COLOR, 24'h000000: RGB emitted for underflowed pixels
- pix_clk  in  1  pixel clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  bpp select: 0 = 1bpp, 1 = 2bpp, 2 = 4bpp, 3 = 8bpp
- pixel_empty_n  in  1  FIFO holds a word
- pixel_word  in  32  FIFO head word
- pixel_deq  out  1  pops the FIFO head this cycle
- pal_we  in  1  palette write strobe
- pal_addr  in  8  palette write index
- pal_data  in  24  palette write data {R,G,B}
- underflow_clr  in  1  clears the sticky underflow flag
- underflow  out  1  sticky: a word fetch found the FIFO empty
- frame_start  out  1  one-cycle pulse at the first cycle of each frame
- hs / vs / de  out  1 each  sync and display enable
- red / green / blue  out  8 each  pixel colour

## Operation
- **Position counters.** posx and posy are signed 16-bit. They count from H_STA = −(H_FP+H_SYNC+H_BP) and V_STA = −(V_FP+V_SYNC+V_BP) up to H_RES−1 and V_RES−1.
  - At posx = H_RES−1, posx wraps to H_STA and posy increments.
  - At posy = V_RES−1, posy wraps to V_STA.
- **Active region.** active = (posx ≥ 0 && posy ≥ 0).
- **Sync.** Sync is asserted at polarity POL while HS_STA < posx ≤ HS_END, where HS_STA = H_STA+H_FP and HS_END = HS_STA+H_SYNC. Vertical sync uses the same rule.
- **Mode latching.** mode is captured into mode_r at posx = H_STA, posy = V_STA, so a change takes effect only at a frame boundary.
- **Pixel addressing.**
  - srcx = posx >> log2(H_SCALE).
  - ppw = 32/bpp pixels per word.
  - slot = srcx mod ppw.
- **Fetch point.** A fetch point is a cycle where active && slot == 0 && (posx mod H_SCALE) == 0.
  - If pixel_empty_n is high: pixel_deq = 1 combinationally, pixel_word is used for this pixel, and it is latched into word_r for the remaining slots.
  - If the FIFO is empty: pixel_deq = 0, underflow is set, and every pixel of that word group outputs UF_COLOR. There is no retry mid-group.
- **Line ends.** A word partially consumed at end of line is discarded. Each line starts a fresh fetch at srcx = 0.
- **Index extraction.** The index is word[slot*bpp +: bpp], least-significant pixel first, zero-extended to 8 bits.
- **Palette.** The palette is 256×24 with a synchronous read.
  - A write occurs on pal_we.
  - A same-cycle read and write to the same address returns the old data.
  - Contents after reset are undefined.
- **Underflow flag.** underflow_clr clears the flag. If a set and a clear happen in the same cycle, set wins.

## Timing
- Every video output (hs, vs, de, RGB, frame_start) reflects the counter state of the previous cycle. This gives exactly one cycle of latency, aligned with the palette read.
- pixel_deq is combinational in the same cycle as the fetch point and is never asserted outside the active region.
- RGB = 0 whenever de = 0. RGB = UF_COLOR for underflowed pixels. Otherwise RGB is the palette output.
- Reset values:
  - hs = ~H_POL and vs = ~V_POL (inactive levels).
  - de = 0, RGB = 0, frame_start = 0, underflow = 0, mode_r = 3.
  - posx = H_STA, posy = V_STA.
  - pixel_deq = 0, which follows because reset leaves the counters outside the active region.
- Reset assertion mid-line or mid-frame immediately forces all of the above.
- The first frame_start pulse appears one cycle after rst_n deasserts.
- Line period is H_RES+H_FP+H_SYNC+H_BP cycles. Frame period is that value times (V_RES+V_FP+V_SYNC+V_BP).

## Test plan
All scenarios use small timing unless stated: H_RES=16, V_RES=4, H_FP=2, H_SYNC=3, H_BP=3, V_FP=1, V_SYNC=1, V_BP=1.

1. **Timing.** Run two frames. Require:
   - a 24-cycle line and a 168-cycle frame;
   - hs low for exactly 3 cycles per line and vs low for exactly one line;
   - de high for 16 cycles per active line;
   - frame_start every 168 cycles.
2. **8bpp.** mode=3, palette[i] = i*24'h010101, FIFO pre-filled with 0x04030201 repeated. Require:
   - first-line RGB = 010101, 020202, 030303, 040404 repeating;
   - 4 pops per line and no underflow.
3. **1bpp with H_SCALE=2.** Word 0x0000_00A5, palette[0]=000000, palette[1]=FFFFFF. Require:
   - pixel pairs following bits 1,0,1,0,0,1,0,1;
   - one pop per line.
4. **Underflow.** FIFO empty at line 0, pixel 4 (8bpp). Require:
   - pixels 4–7 = UF_COLOR and no pop;
   - underflow sticky until underflow_clr;
   - a same-cycle set and clear leaves underflow = 1.
5. **Mode change mid-frame.** Switch mode 3→0 at posy=1. Require the unpacking to stay at 8bpp until the next frame_start, then change to 1bpp.
6. **Reset mid-active.** Assert rst_n=0 at posx=5, posy=2. Require:
   - de, RGB and pixel_deq = 0 and hs/vs inactive immediately;
   - after release, the counters restart from H_STA/V_STA.
